// File: rtl/result_demux_pkg.sv
// rtl/result_demux_pkg.sv - shared select constants and default sizing for result_demux_2
package result_demux_pkg;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - synchronous FIFO with occupancy count and flush; push/pop qualified by the caller
module demux_fifo
  import result_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately left out of reset and flush; only pointers/count matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign data  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/result_demux_2.sv
// rtl/result_demux_2.sv - registered 1-to-2 result demux with an independent FIFO per destination
module result_demux_2
  import result_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic [CW-1:0]    out_a_count,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic [CW-1:0]    out_b_count
);

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;
  logic pop_a;
  logic pop_b;

  // Readiness depends only on the selected FIFO's full flag, never on consumer ready.
  assign in_ready = !flush && !((in_sel == DEST_B) ? full_b : full_a);
  assign push_a   = in_valid && in_ready && (in_sel == DEST_A);
  assign push_b   = in_valid && in_ready && (in_sel == DEST_B);
  assign pop_a    = out_a_valid && out_a_ready && !flush;
  assign pop_b    = out_b_valid && out_b_ready && !flush;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push_a),
    .push_data (in_data),
    .pop       (pop_a),
    .valid     (out_a_valid),
    .data      (out_a_data),
    .count     (out_a_count),
    .full      (full_a)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push_b),
    .push_data (in_data),
    .pop       (pop_b),
    .valid     (out_b_valid),
    .data      (out_b_data),
    .count     (out_b_count),
    .full      (full_b)
  );

endmodule

// File: doc/result_demux_2.md
# result_demux_2

Registered 1-to-2 result demultiplexer with valid/ready handshake and an independent FIFO per output. It splits a single 32-bit producer stream, such as the datapath result bus, between two consumers, such as register-file write-back and memory write data. A per-word select steers each word to one destination. Each destination buffers up to DEPTH words so that a stalled consumer does not block the other one.

## Interface
Parameters:
- WIDTH, 32, data width of every word.
- DEPTH, 2, entries per output FIFO. Must be a power of two and at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy counters (derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of both FIFOs.
- in_valid  input  1  producer word present.
- in_ready  output  1  word accepted this cycle when in_valid is also 1.
- in_sel  input  1  destination: 0 routes to output A, 1 routes to output B.
- in_data  input  WIDTH  word.
- out_a_valid  output  1  FIFO A non-empty.
- out_a_ready  input  1  consumer A accepts the head word.
- out_a_data  output  WIDTH  head word of FIFO A.
- out_a_count  output  CW  occupancy of FIFO A.
- out_b_valid, out_b_ready, out_b_data, out_b_count: identical to the A ports, for FIFO B.

## Operation
- Push rule: a word is pushed into the FIFO selected by in_sel when in_valid && in_ready. The other FIFO is never written in that cycle.
- in_ready = !flush && !full of the FIFO selected by in_sel. It is combinational from in_sel, flush and the full flags.
- Producer obligation: hold in_data and in_sel stable while in_valid=1 and in_ready=0.
- Full FIFO: in_ready=0 for that destination, even if that output is popping in the same cycle. No pass-through to a full FIFO. A push to the other, non-full FIFO proceeds normally.
- Pop rule: a pop occurs on out_x_valid && out_x_ready.
  - Simultaneous push and pop on a non-full FIFO leaves out_x_count unchanged.
  - The head advances to the next entry in FIFO order.
- out_x_valid = (out_x_count != 0).
- out_x_data:
  - Driven from the FIFO entry at the read pointer.
  - Forced to 0 when the FIFO is empty.
  - Must not change while valid=1 and ready=0.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - Full/empty is decided from the count, never from pointer equality alone.
- flush=1:
  - Next edge: both counts become 0 and both pointers become 0.
  - Any pop in that cycle is ignored.
  - in_ready=0, so no push occurs; flush wins over every simultaneous event.
  - Entry storage is not cleared.
- Ordering: word order is preserved per output. There is no ordering relation between A and B.
- Reset (rst_n=0, asynchronous):
  - Pointers and counts go to 0, so out_x_valid=0, out_x_data=0, out_x_count=0.
  - in_ready follows its formula, giving 1 when flush=0.
  - Reset mid-transfer discards all buffered words. No transfer completes while rst_n=0.

## Timing
- Latency: a word accepted at edge N is visible on out_x_valid/out_x_data after edge N, so it is poppable in cycle N+1.
- Throughput: one push per cycle, plus one pop per output per cycle. Sustained 1 word/cycle to either output while its consumer holds ready=1.
- Combinational paths:
  - in_sel/flush -> in_ready.
  - No path from out_x_ready to in_ready.
  - No path from in_* to out_x_*.
- The flush effect is visible one edge after flush is sampled high.

## Structure
- Shared package, result_demux_pkg:
  - DEST_A=1'b0 and DEST_B=1'b1 select constants.
  - The default WIDTH and DEPTH localparams.
- One sub-module, demux_fifo:
  - Parameterised WIDTH/DEPTH synchronous FIFO with count, flush, and push/pop qualified by the top.
  - Instantiated twice.
- The top holds only the push steering and the in_ready logic.

## Test plan
- Reset-and-steer: after reset, check every output at its reset value and in_ready=1. Push 0x11111111 (sel=0), then 0x22222222 (sel=1), both consumers ready=1. Expect out_a_data=0x11111111 one cycle after acceptance and out_b_data=0x22222222 one cycle later. Counts return to 0.
- Full/backpressure (DEPTH=2): out_a_ready=0, push 0xA0, 0xA1, then try 0xA2 to A. Expect in_ready=0 with count=2. With in_sel=1, 0xB0 is accepted. Raise out_a_ready and expect A to deliver 0xA0, 0xA1, 0xA2 in order.
- Wrap-around: send 10 words 0..9 to B with random out_b_ready. Expect exact order, with no loss or duplication across pointer wrap.
- Simultaneous push+pop on count=1: count stays 1 and the head advances to the new word.
- Flush with both FIFOs holding 2 words, while in_valid=1 and the consumers are ready. Expect in_ready=0 that cycle, no pop counted, and both counts=0 with valids=0 on the next cycle.
- Async reset mid-stream: drop rst_n between edges while words are buffered. Expect immediate valid=0, data=0, count=0. The first word after reset is delivered correctly.
